s100_bus_decoder: RTL and testbench

Parametrised system bus decoder for the S-100 designs: sits between the i8080 core and its memory/I/O slaves. Latches the 8080 status byte on `sync`, decodes up to `NMEM` memory windows and `NIO` I/O windows, and muxes slave read data onto the CPU input bus. Generates per-window wait states through a `ready` handshake, and supplies an interrupt-acknowledge opcode. Optionally overlays a turn-key boot jump on the first three memory reads after reset.

---
 rtl/s100_bus_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_s100_bus_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/s100_bus_decoder.sv
// s100_bus_decoder
//   System bus decoder that sits between an i8080 core and its memory and I/O
//   slaves. It latches the status byte on sync, decodes NMEM memory windows
//   on addr[15:8] and NIO I/O windows on addr[7:0], muxes slave read data
//   onto idata, inserts per-window wait states through ready, and answers
//   interrupt acknowledge with INTA_OP.
//
//   Optional feature: define S100_BUS_DECODER_BOOT_EN to compile in the
//   turn-key boot overlay. It returns JMP BOOT_ADDR (C3, lo, hi) on the
//   first three memory reads after reset. Without the macro, boot_active is
//   tied to 0.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   addr         CPU address
//   odata        CPU data out (status byte while sync=1)
//   sync         status strobe
//   rd           CPU read strobe, active high
//   wr_n         CPU write strobe, active low
//   mem_rdata    packed NMEM x 8 memory read data
//   io_rdata     packed NIO x 8 I/O read data
//   idata        CPU data in
//   ready        0 = wait state
//   mem_rd/we    one-hot memory strobes
//   io_rd/we     one-hot I/O strobes
//   status       latched status byte
//   boot_active  boot overlay in effect
//
// Wait FSM
//   state  | meaning
//   W_IDLE | ready=1, waiting for an armed access to start
//   W_WAIT | ready=0, cnt counts the remaining wait clks
//
// Boot FSM (S100_BUS_DECODER_BOOT_EN only)
//   state  | meaning
//   B_OP   | next memory read returns the JMP opcode C3
//   B_LO   | next memory read returns BOOT_ADDR[7:0]
//   B_HI   | next memory read returns BOOT_ADDR[15:8]
//   B_DONE | overlay finished, normal decode
module s100_bus_decoder #(
  parameter int                NMEM      = 4,
  parameter int                NIO       = 2,
  parameter logic [NMEM*8-1:0] MEM_BASE  = {8'hFD, 8'hFB, 8'h20, 8'h00},
  parameter logic [NMEM*8-1:0] MEM_MASK  = {8'hFF, 8'hFF, 8'hE0, 8'hE0},
  parameter logic [NMEM-1:0]   MEM_RO    = 4'b1000,
  parameter logic [NMEM*4-1:0] MEM_WAIT  = 16'h0000,
  parameter logic [NIO*8-1:0]  IO_BASE   = {8'h10, 8'h00},
  parameter logic [NIO*8-1:0]  IO_MASK   = {8'hFE, 8'hFE},
  parameter logic [15:0]       BOOT_ADDR = 16'hFD00,
  parameter logic [7:0]        INTA_OP   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [7:0]        odata,
  input  logic              sync,
  input  logic              rd,
  input  logic              wr_n,
  input  logic [NMEM*8-1:0] mem_rdata,
  input  logic [NIO*8-1:0]  io_rdata,
  output logic [7:0]        idata,
  output logic              ready,
  output logic [NMEM-1:0]   mem_rd,
  output logic [NMEM-1:0]   mem_we,
  output logic [NIO-1:0]    io_rd,
  output logic [NIO-1:0]    io_we,
  output logic [7:0]        status,
  output logic              boot_active
);

  typedef enum logic {W_IDLE, W_WAIT} wstate_t;

  logic [7:0] status_q, status_d;
  logic       armed_q, armed_d;
  logic [3:0] cnt_q, cnt_d;
  wstate_t    wstate_q, wstate_d;

  logic st_inta, st_out, st_inp, st_mem;
  logic [7:0] boot_byte;

  assign st_inta = status_q[0];
  assign st_out  = status_q[4];
  assign st_inp  = status_q[6];
  assign st_mem  = ~(status_q[6] | status_q[4] | status_q[0]);

  // Address decode. Loops run high-to-low so the lowest window wins overlaps.
  logic [NMEM-1:0] mem_sel;
  logic            mem_any;
  logic [7:0]      mem_rdsel;
  logic            mem_ro_sel;
  logic [3:0]      mem_wait_sel;
  logic [NIO-1:0]  io_sel;
  logic            io_any;
  logic [7:0]      io_rdsel;

  always_comb begin
    mem_sel      = '0;
    mem_any      = 1'b0;
    mem_rdsel    = 8'h00;
    mem_ro_sel   = 1'b0;
    mem_wait_sel = 4'd0;
    for (int k = NMEM - 1; k >= 0; k--) begin
      if ((addr[15:8] & MEM_MASK[8*k +: 8]) == (MEM_BASE[8*k +: 8] & MEM_MASK[8*k +: 8])) begin
        mem_sel      = '0;
        mem_sel[k]   = 1'b1;
        mem_any      = 1'b1;
        mem_rdsel    = mem_rdata[8*k +: 8];
        mem_ro_sel   = MEM_RO[k];
        mem_wait_sel = MEM_WAIT[4*k +: 4];
      end
    end
  end

  always_comb begin
    io_sel   = '0;
    io_any   = 1'b0;
    io_rdsel = 8'h00;
    for (int j = NIO - 1; j >= 0; j--) begin
      if ((addr[7:0] & IO_MASK[8*j +: 8]) == (IO_BASE[8*j +: 8] & IO_MASK[8*j +: 8])) begin
        io_sel    = '0;
        io_sel[j] = 1'b1;
        io_any    = 1'b1;
        io_rdsel  = io_rdata[8*j +: 8];
      end
    end
  end

  assign ready = (wstate_q == W_IDLE);

  // Read path, highest priority first.
  always_comb begin
    idata  = 8'hFF;
    mem_rd = '0;
    io_rd  = '0;
    if (st_inta) begin
      idata = INTA_OP;
    end else if (boot_active) begin
      idata = boot_byte;
    end else if (st_inp) begin
      if (io_any) begin
        io_rd = io_sel & {NIO{rd}};
        idata = io_rdsel;
      end
    end else if (st_mem && mem_any) begin
      mem_rd = mem_sel & {NMEM{rd}};
      idata  = mem_rdsel;
    end
  end

  // Write strobes are gated by ready so a slave sees them only on ready clks.
  assign io_we  = (st_out && io_any && !wr_n && ready) ? io_sel : '0;
  assign mem_we = (st_mem && mem_any && !mem_ro_sel && !wr_n && ready) ? mem_sel : '0;

  // Wait FSM. A sync in the same clk as the access start keeps the flag set.
  always_comb begin
    wstate_d = wstate_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    status_d = sync ? odata : status_q;
    case (wstate_q)
      W_IDLE: begin
        if (armed_q && (rd || !wr_n)) begin
          armed_d = 1'b0;
          if (st_mem && !boot_active && mem_any && (mem_wait_sel != 4'd0)) begin
            cnt_d    = mem_wait_sel;
            wstate_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    if (sync) armed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      status_q <= 8'h00;
      armed_q  <= 1'b0;
      cnt_q    <= 4'd0;
      wstate_q <= W_IDLE;
    end else begin
      status_q <= status_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      wstate_q <= wstate_d;
    end
  end

  assign status = status_q;

`ifdef S100_BUS_DECODER_BOOT_EN
  typedef enum logic [1:0] {B_OP, B_LO, B_HI, B_DONE} bstate_t;

  bstate_t boot_q, boot_d;
  logic    rd_q;

  // A memory read completes on the clk where rd falls.
  always_comb begin
    boot_d = boot_q;
    if (rd_q && !rd && st_mem) begin
      case (boot_q)
        B_OP:    boot_d = B_LO;
        B_LO:    boot_d = B_HI;
        B_HI:    boot_d = B_DONE;
        default: boot_d = boot_q;
      endcase
    end
  end

  always_comb begin
    case (boot_q)
      B_OP:    boot_byte = 8'hC3;
      B_LO:    boot_byte = BOOT_ADDR[7:0];
      B_HI:    boot_byte = BOOT_ADDR[15:8];
      default: boot_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      boot_q <= B_OP;
      rd_q   <= 1'b0;
    end else begin
      boot_q <= boot_d;
      rd_q   <= rd;
    end
  end

  assign boot_active = (boot_q != B_DONE);
`else
  // Never selected: boot_active is tied low in this build.
  assign boot_byte   = BOOT_ADDR[7:0];
  assign boot_active = 1'b0;
`endif

endmodule

// File: tb/tb_s100_bus_decoder.sv
module tb_s100_bus_decoder;

`ifdef S100_BUS_DECODER_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  localparam logic [15:0] P_WAIT = 16'h0123;  // w0=3, w1=2, w2=1, w3=0

  // Reference window tables, indexed by window number.
  logic [7:0] m_base   [4] = '{8'h00, 8'h20, 8'hFB, 8'hFD};
  logic [7:0] m_mask   [4] = '{8'hE0, 8'hE0, 8'hFF, 8'hFF};
  bit         m_ro     [4] = '{0, 0, 0, 1};
  int         m_waitc  [4] = '{3, 2, 1, 0};
  logic [7:0] i_base   [2] = '{8'h00, 8'h10};
  logic [7:0] i_mask   [2] = '{8'hFE, 8'hFE};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  odata = 8'h0;
  logic        sync = 1'b0;
  logic        rd = 1'b0;
  logic        wr_n = 1'b1;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] io_rdata = 16'h0;
  logic [7:0]  idata;
  logic        ready;
  logic [3:0]  mem_rd, mem_we;
  logic [1:0]  io_rd, io_we;
  logic [7:0]  status;
  logic        boot_active;

  s100_bus_decoder #(.MEM_WAIT(P_WAIT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .odata(odata), .sync(sync),
    .rd(rd), .wr_n(wr_n), .mem_rdata(mem_rdata), .io_rdata(io_rdata),
    .idata(idata), .ready(ready), .mem_rd(mem_rd), .mem_we(mem_we),
    .io_rd(io_rd), .io_we(io_we), .status(status), .boot_active(boot_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] idata;
    logic       ready;
    logic [3:0] mem_rd;
    logic [3:0] mem_we;
    logic [1:0] io_rd;
    logic [1:0] io_we;
    logic [7:0] status;
    logic       boot_active;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] ms_status;
  bit         ms_armed;
  int         ms_waits;
  int         ms_boot;
  bit         ms_rd_prev;
  // Inputs that were held during the cycle that just ended
  logic        p_reset = 1'b0, p_sync = 1'b0, p_rd = 1'b0, p_wr_n = 1'b1;
  logic [7:0]  p_odata = 8'h0;
  logic [15:0] p_addr = 16'h0;

  function automatic int mem_hit(logic [15:0] a);
    for (int k = 0; k < 4; k++)
      if ((a[15:8] & m_mask[k]) == (m_base[k] & m_mask[k])) return k;
    return -1;
  endfunction

  function automatic int io_hit(logic [15:0] a);
    for (int j = 0; j < 2; j++)
      if ((a[7:0] & i_mask[j]) == (i_base[j] & i_mask[j])) return j;
    return -1;
  endfunction

  function automatic bit is_mem(logic [7:0] s);
    return (s[6] == 1'b0) && (s[4] == 1'b0) && (s[0] == 1'b0);
  endfunction

  task automatic model_step();
    int k;
    bit boot_on;
    if (!p_reset) begin
      ms_status = 8'h00; ms_armed = 0; ms_waits = 0; ms_boot = 0; ms_rd_prev = 0;
      return;
    end
    boot_on = BOOT_EN && (ms_boot < 3);
    k = mem_hit(p_addr);
    if (ms_waits > 0) begin
      ms_waits--;
    end else if (ms_armed && (p_rd || !p_wr_n)) begin
      ms_armed = 0;
      if (is_mem(ms_status) && !boot_on && k >= 0 && m_waitc[k] > 0) ms_waits = m_waitc[k];
    end
    if (p_sync) ms_armed = 1;
    if (ms_rd_prev && !p_rd && is_mem(ms_status) && ms_boot < 3) ms_boot++;
    ms_rd_prev = p_rd;
    if (p_sync) ms_status = p_odata;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int k, j;
    bit boot_on;
    logic [15:0] boot_target = 16'hFD00;
    e.idata = 8'hFF; e.mem_rd = '0; e.mem_we = '0; e.io_rd = '0; e.io_we = '0;
    e.ready = (ms_waits == 0);
    e.status = ms_status;
    boot_on = BOOT_EN && (ms_boot < 3);
    e.boot_active = boot_on;
    k = mem_hit(addr);
    j = io_hit(addr);
    if (ms_status[0]) e.idata = 8'hFF;  // RST 7
    else if (boot_on) e.idata = (ms_boot == 0) ? 8'hC3 : (ms_boot == 1) ? boot_target[7:0] : boot_target[15:8];
    else if (ms_status[6]) begin
      if (j >= 0) begin e.io_rd[j] = rd; e.idata = io_rdata[8*j +: 8]; end
    end else if (is_mem(ms_status) && k >= 0) begin
      e.mem_rd[k] = rd; e.idata = mem_rdata[8*k +: 8];
    end
    if (ms_status[4] && j >= 0) e.io_we[j] = !wr_n && e.ready;
    if (is_mem(ms_status) && k >= 0 && !m_ro[k]) e.mem_we[k] = !wr_n && e.ready;
    return e;
  endfunction

  // One clock of stimulus: update the model for the edge just taken, apply new
  // inputs, and queue what the DUT should present during this cycle.
  task automatic cyc(input logic rst, input logic s, input logic [7:0] od,
                     input logic r, input logic w_n, input logic [15:0] a);
    @(posedge clk); #1;
    model_step();
    reset = rst; sync = s; odata = od; rd = r; wr_n = w_n; addr = a;
    mem_rdata = $urandom; io_rdata = 16'($urandom);
    p_reset = rst; p_sync = s; p_odata = od; p_rd = r; p_wr_n = w_n; p_addr = a;
    q.push_back(expect_now());
  endtask

  // sync cycle, n access clks, one idle clk
  task automatic bus(input logic [7:0] st, input logic [15:0] a, input bit is_wr, input int n);
    cyc(1, 1, st, 0, 1, a);
    repeat (n) cyc(1, 0, st, !is_wr, is_wr ? 1'b0 : 1'b1, a);
    cyc(1, 0, st, 0, 1, a);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("idata", idata, e.idata);
        chk("ready", {7'b0, ready}, {7'b0, e.ready});
        chk("mem_rd", {4'b0, mem_rd}, {4'b0, e.mem_rd});
        chk("mem_we", {4'b0, mem_we}, {4'b0, e.mem_we});
        chk("io_rd", {6'b0, io_rd}, {6'b0, e.io_rd});
        chk("io_we", {6'b0, io_we}, {6'b0, e.io_we});
        chk("status", status, e.status);
        chk("boot_active", {7'b0, boot_active}, {7'b0, e.boot_active});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  logic [7:0] st_pool [5] = '{8'h00, 8'h10, 8'h40, 8'h01, 8'h00};

  initial begin
    logic [7:0]  st;
    logic [15:0] a;
    int sel;
    // reset
    cyc(0, 0, 8'h00, 0, 1, 16'h0000);
    cyc(0, 0, 8'h00, 0, 1, 16'h0000);
    cyc(1, 0, 8'h00, 0, 1, 16'h0000);
    // boot overlay (or plain window-0 reads when the overlay is not built)
    bus(8'h00, 16'h0000, 0, 2);
    bus(8'h00, 16'h0001, 0, 2);
    bus(8'h00, 16'h0002, 0, 2);
    // window 0 read with 3 waits
    bus(8'h00, 16'h1234, 0, 6);
    // window 1 (2 waits) and window 2 (1 wait)
    bus(8'h00, 16'h2345, 0, 4);
    bus(8'h00, 16'hFB07, 0, 3);
    // OUT to port 0x11, then write to read-only window 3
    bus(8'h10, 16'h0011, 1, 2);
    bus(8'h00, 16'hFD10, 1, 2);
    // writable window write with waits
    bus(8'h00, 16'h0040, 1, 5);
    // INP from port 0x00/0x10
    bus(8'h40, 16'h0000, 0, 2);
    bus(8'h40, 16'h0010, 0, 2);
    // INTA, unmapped memory, unmapped I/O
    bus(8'h01, 16'h1234, 0, 2);
    bus(8'h00, 16'h8000, 0, 2);
    bus(8'h40, 16'h0033, 0, 2);
    // reset while in WAIT with cnt=2
    cyc(1, 1, 8'h00, 0, 1, 16'h1234);
    cyc(1, 0, 8'h00, 1, 1, 16'h1234);
    cyc(1, 0, 8'h00, 1, 1, 16'h1234);
    cyc(0, 0, 8'h00, 1, 1, 16'h1234);
    cyc(1, 0, 8'h00, 0, 1, 16'h1234);
    cyc(1, 0, 8'h00, 0, 1, 16'h1234);
    // randomized bus traffic
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 5);
      st = (sel == 5) ? 8'($urandom) : st_pool[sel];
      case ($urandom_range(0, 6))
        0: a = {3'b000, 13'($urandom)};
        1: a = {3'b001, 13'($urandom)};
        2: a = {8'hFB, 8'($urandom)};
        3: a = {8'hFD, 8'($urandom)};
        4: a = {8'($urandom), 7'h00, 1'($urandom)};
        5: a = {8'($urandom), 7'h08, 1'($urandom)};
        default: a = 16'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0) cyc(0, 0, 8'h00, 0, 1, a);
      bus(st, a, $urandom_range(0, 1) == 1, $urandom_range(1, 6));
    end
    cyc(1, 0, 8'h00, 0, 1, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
